// File: rtl/mod_arith_pkg.sv
// Shared constants for the modular arithmetic blocks (subtractor, adder).
package mod_arith_pkg;

    localparam int BIT_SIZE_DEF = 60;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/mod_sub_core.sv
// Combinational modular subtract: M = (A - B) mod q, with a single +q correction on borrow.
module mod_sub_core #(
    parameter int W = 60
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] q,
    output logic [W-1:0] M,
    output logic         borrow
);

    logic [W:0] d;

    assign d      = {1'b0, A} - {1'b0, B};
    assign borrow = d[W];
    // Wraparound of the +q is intended: it lands back inside [0, q) for in-range operands.
    assign M      = borrow ? (d[W-1:0] + q) : d[W-1:0];

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage valid/ready pipelined modular subtractor with consumed-result counter.
// Define MOD_SUB_RANGE_CHK_EN to add the err output flagging out-of-range operands.
module mod_sub_pipe
    import mod_arith_pkg::*;
#(
    parameter int BIT_SIZE = BIT_SIZE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_SIZE-1:0] A,
    input  logic [BIT_SIZE-1:0] B,
    input  logic [BIT_SIZE-1:0] q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIT_SIZE-1:0] M,
`ifdef MOD_SUB_RANGE_CHK_EN
    output logic                err,
`endif
    output logic [CNT_W-1:0]    op_cnt
);

    logic                s1_valid;
    logic [BIT_SIZE-1:0] s1_a;
    logic [BIT_SIZE-1:0] s1_b;
    logic [BIT_SIZE-1:0] s1_q;
    logic [BIT_SIZE-1:0] core_m;
    logic                core_borrow;
    logic                s2_adv;
    logic                in_fire;
    logic                out_fire;

    mod_sub_core #(.W(BIT_SIZE)) u_core (
        .A      (s1_a),
        .B      (s1_b),
        .q      (s1_q),
        .M      (core_m),
        .borrow (core_borrow)
    );

    // S2 frees up when empty or drained this cycle; S1 may refill in the same cycle.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= A;
                s1_b <= B;
                s1_q <= q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            M         <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) M <= core_m;
        end
    end

`ifdef MOD_SUB_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            err <= (s1_a >= s1_q) || (s1_b >= s1_q);
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) op_cnt <= '0;
        else if (out_fire) op_cnt <= op_cnt + 1'b1;
    end

    // Borrow is only observable through M; kept on the core for reuse and debug.
    logic unused_borrow;
    assign unused_borrow = core_borrow & in_fire;

endmodule

// File: doc/mod_sub_pipe.md
MOD_SUB_PIPE -- requirements
Module: mod_sub_pipe

Interface
REQ-001 SHALL have parameter BIT_SIZE, default 60, operand/modulus/result width.
REQ-002 SHALL have parameter CNT_W, default 16, completed-operation counter width.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set A/B/q presented.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-007 SHALL have port A  input  BIT_SIZE  minuend, residue mod q.
REQ-008 SHALL have port B  input  BIT_SIZE  subtrahend, residue mod q.
REQ-009 SHALL have port q  input  BIT_SIZE  modulus, nonzero, sampled per operation.
REQ-010 SHALL have port out_valid  output  1  M holds a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer takes M this cycle.
REQ-012 SHALL have port M  output  BIT_SIZE  (A - B) mod q.
REQ-013 SHALL have port op_cnt  output  CNT_W  count of results consumed.

Function
REQ-014 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-015 SHALL use two register stages: S1 captures A, B, q, valid; S2 holds M and out_valid.
REQ-016 SHALL compute in S1->S2 path D = {1'b0,A} - {1'b0,B} at BIT_SIZE+1 bits; borrow = D[BIT_SIZE].
REQ-017 SHALL load M = D[BIT_SIZE-1:0] + q (mod 2^BIT_SIZE) when borrow, else D[BIT_SIZE-1:0].
REQ-018 SHALL give latency 2 cycles from input handshake to out_valid with no backpressure; throughput 1 op/cycle.
REQ-019 SHALL advance S2 when !out_valid || out_ready; S1 advances into S2 under the same condition.
REQ-020 SHALL drive in_ready = !S1.valid || S2-advance (combinational from out_ready).
REQ-021 SHALL hold M and out_valid stable while out_valid && !out_ready; no result dropped or duplicated.
REQ-022 SHALL, on simultaneous output take and input accept with both stages full, shift S1->S2 and load S1 in the same cycle.
REQ-023 SHALL give A == B result 0 with no correction; A=0, B=q-1 result 1.
REQ-024 SHALL leave results for out-of-range operands (A>=q or B>=q) unspecified except per REQ-030.
REQ-025 SHALL increment op_cnt on each output handshake, wrapping 2^CNT_W-1 -> 0.

Reset
REQ-026 SHALL on rstn low immediately clear S1 and S2 valids, S1 operands, M, op_cnt to 0.
REQ-027 SHALL drive in_ready 1, out_valid 0, M 0, op_cnt 0 during and after reset.
REQ-028 SHALL discard in-flight operations on reset mid-operation; none emitted after release.

Configuration
REQ-029 SHALL compile a range-check feature only when macro MOD_SUB_RANGE_CHK_EN is defined.
REQ-030 SHALL with MOD_SUB_RANGE_CHK_EN add output port err  output  1, travelling with its result, set when S1 A>=q or B>=q, reset 0; without it no err port and no comparators.

Structure
REQ-031 SHALL place BIT_SIZE default and CNT_W default constants in shared package mod_arith_pkg, reused by the modular adder.
REQ-032 SHALL isolate subtract-and-correct datapath in combinational sub-module mod_sub_core (A, B, q -> M, borrow).

Verification
REQ-033 SHALL cover q=97, A=10, B=30, out_ready=1 -> M=77, out_valid 2 cycles after accept, op_cnt=1.
REQ-034 SHALL cover q=97, A=50, B=20 then A=5, B=5 back-to-back -> M=30 then M=0 on consecutive cycles.
REQ-035 SHALL cover q=2^60-1, A=0, B=2^60-2 -> M=1 (full-width borrow path).
REQ-036 SHALL cover out_ready=0 for 5 cycles with 3 ops offered -> 2 accepted, in_ready=0, M stable, resumes in order with no loss.
REQ-037 SHALL cover rstn low one cycle with both stages full -> out_valid=0, op_cnt=0, no stale result after release.
REQ-038 SHALL cover, with MOD_SUB_RANGE_CHK_EN, q=97, A=97, B=1 -> err=1 with that result; A=96, B=1 -> err=0.
